fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/fifo_uart_tx.sv | 141 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared UART definitions: transmitter state encoding, the 16x oversample
// ratio, and a helper that sizes the tick counter so it can also count the
// stop bit, which may be longer than one oversampled bit.
package uart_pkg;

   localparam int OSR = 16;   // oversample ticks per data bit

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // The tick counter must reach OSR-1 in START/DATA and SB_TICK-1 in STOP.
   // It is 4 bits for 1 stop bit, and widens only when SB_TICK > 16
   // (1.5 or 2 stop bits).
   function automatic int tick_cnt_w(input int sb_tick);
      int w_osr;
      int w_sb;
      w_osr = $clog2(OSR);
      w_sb  = $clog2(sb_tick);
      return (w_sb > w_osr) ? w_sb : w_osr;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
// Free-running divider producing a one-clk s_tick pulse every DVSR clocks
// (16x the baud rate). The count runs 0..DVSR-1 and pulses on DVSR-1.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (count cleared to 0)
//   s_tick - oversample tick strobe
module baud_tick_gen #(
   parameter int DVSR   = 163,
   parameter int DVSR_W = 8
) (
   input  logic clk,
   input  logic reset,
   output logic s_tick
);

   logic [DVSR_W-1:0] cnt_q;
   logic [DVSR_W-1:0] cnt_d;

   always_comb begin
      s_tick = (cnt_q == DVSR_W'(DVSR - 1));
      cnt_d  = s_tick ? '0 : cnt_q + DVSR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// UART transmitter fed directly from a show-ahead FIFO. Whenever the
// transmitter is idle and the FIFO is non-empty it pops one word, then sends
// start bit, DBIT data bits LSB first, and SB_TICK oversample ticks of stop.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-high reset (aborts any frame)
//   fifo_empty   - upstream FIFO empty flag
//   fifo_r_data  - upstream FIFO head word (valid when fifo_empty = 0)
//   fifo_rd      - one-cycle pop strobe, only ever asserted in IDLE
//   tx           - registered serial output, idle high
//   tx_busy      - high in every state except IDLE
//   tx_done_tick - one-cycle pulse on the last stop tick of each frame
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 163,
   parameter int DVSR_W  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fifo_empty,
   input  logic [DBIT-1:0] fifo_r_data,
   output logic            fifo_rd,
   output logic            tx,
   output logic            tx_busy,
   output logic            tx_done_tick
);

   localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam int S_W = tick_cnt_w(SB_TICK);

   uart_state_e     state_q, state_d;
   logic [S_W-1:0]  s_q, s_d;
   logic [N_W-1:0]  n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic            tx_q, tx_d;
   logic            s_tick;

   baud_tick_gen #(
      .DVSR   (DVSR),
      .DVSR_W (DVSR_W)
   ) u_baud_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .s_tick (s_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      n_d          = n_q;
      b_d          = b_q;
      fifo_rd      = 1'b0;
      tx_done_tick = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The pop is gated by reset so the FIFO never loses a word
            // while the transmitter is being held in reset.
            if (!fifo_empty && !reset) begin
               fifo_rd = 1'b1;
               b_d     = fifo_r_data;
               s_d     = '0;
               state_d = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_W'(OSR - 1)) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_W'(OSR - 1)) begin
                  s_d = '0;
                  b_d = b_q >> 1;
                  if (n_q == N_W'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_d = n_q + N_W'(1);
                  end
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == S_W'(SB_TICK - 1)) begin
                  tx_done_tick = 1'b1;
                  state_d      = IDLE;
               end else begin
                  s_d = s_q + S_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The line level is derived from the state being entered, so tx_q always
   // matches state_q: low through START, b[0] during DATA, high otherwise.
   always_comb begin
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = b_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx      = tx_q;
   assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int DVSR    = 4;
   localparam int BITC    = 16 * DVSR;              // clks per data bit
   localparam int HB      = BITC / 2;               // mid-bit sample offset
   localparam int TOTAL   = 16 * (DBIT + 1) + SB_TICK;  // ticks per frame

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fifo_empty = 1'b1;
   logic [7:0] fifo_r_data = 8'h00;
   logic fifo_rd, tx, tx_busy, tx_done_tick;

   // second instance with two stop bits
   logic r32 = 1'b1;
   logic f32_empty = 1'b1;
   logic [7:0] f32_data = 8'h80;
   logic f32_rd, tx32, busy32, done32;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_W(8)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
      .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick));

   fifo_uart_tx #(.DBIT(8), .SB_TICK(32), .DVSR(DVSR), .DVSR_W(8)) dut32 (
      .clk(clk), .reset(r32), .fifo_empty(f32_empty), .fifo_r_data(f32_data),
      .fifo_rd(f32_rd), .tx(tx32), .tx_busy(busy32), .tx_done_tick(done32));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // ---------------- upstream FIFO emulation ----------------
   logic [7:0] q[$];
   logic [7:0] exp_words[$];
   bit pop_req = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (pop_req) begin
            if (q.size() > 0) void'(q.pop_front());
            pop_req = 0;
         end
         fifo_empty = (q.size() == 0);
         // junk on the data bus whenever the FIFO is empty
         fifo_r_data = fifo_empty ? 8'($urandom) : q[0];
      end
   end

   task automatic push(input logic [7:0] w);
      q.push_back(w);
      exp_words.push_back(w);
   endtask

   // ---------------- reference model + line decoder ----------------
   bit model_busy = 0;
   int T = 0;               // oversample ticks consumed in current frame
   int ph = 0;              // tick phase since reset
   logic [7:0] word = 8'h00;
   int rd_cnt = 0, done_cnt = 0;

   bit dec_active = 0;
   int dec_cnt = 0;
   logic [9:0] dec_bits = '0;
   logic [9:0] last_bits = '0;
   logic [7:0] dec_q[$];
   logic prev_tx = 1'b1;
   int run_len = 0;
   int runs[$];

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("reset_tx", int'(tx), 1);
            chk("reset_rd", int'(fifo_rd), 0);
            chk("reset_busy", int'(tx_busy), 0);
            chk("reset_done", int'(tx_done_tick), 0);
            model_busy = 0; T = 0; ph = 0; pop_req = 0; dec_active = 0;
         end else begin
            bit tick;
            logic e_tx, e_rd, e_busy, e_done;
            tick = (ph == DVSR - 1);
            ph = (ph + 1) % DVSR;
            if (!model_busy) begin
               e_rd = !fifo_empty; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end else begin
               e_rd = 1'b0; e_busy = 1'b1;
               if (T < 16) e_tx = 1'b0;
               else if (T < 16 * (DBIT + 1)) e_tx = word[(T - 16) / 16];
               else e_tx = 1'b1;
               e_done = tick && (T + 1 == TOTAL);
            end
            chk("cyc_tx", int'(tx), int'(e_tx));
            chk("cyc_rd", int'(fifo_rd), int'(e_rd));
            chk("cyc_busy", int'(tx_busy), int'(e_busy));
            chk("cyc_done", int'(tx_done_tick), int'(e_done));
            if (!model_busy) begin
               if (e_rd) begin model_busy = 1; T = 0; word = fifo_r_data; end
            end else if (tick) begin
               T++;
               if (T == TOTAL) model_busy = 0;
            end
            if (fifo_rd) begin pop_req = 1; rd_cnt++; end
            if (tx_done_tick) done_cnt++;
            // independent mid-bit line decoder
            if (dec_active) begin
               dec_cnt++;
               if (dec_cnt >= HB && ((dec_cnt - HB) % BITC) == 0) begin
                  int i;
                  i = (dec_cnt - HB) / BITC;
                  dec_bits[i] = tx;
                  if (i == 9) begin
                     dec_active = 0;
                     last_bits = dec_bits;
                     chk("framing", int'({dec_bits[9], dec_bits[0]}), 2);
                     dec_q.push_back(dec_bits[8:1]);
                  end
               end
            end else if (prev_tx && !tx) begin
               dec_active = 1; dec_cnt = 0;
            end
            if (tx == prev_tx) run_len++;
            else begin runs.push_back(run_len); run_len = 1; end
         end
         prev_tx = tx;
      end
   end

   // ---------------- SB_TICK=32 instance monitor ----------------
   int pops32 = 0, hi_len = 0, falls32 = 0, stop_run = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!r32) begin
            if (f32_rd) pops32++;
            if (tx32) hi_len++;
            else begin
               if (hi_len > 0) begin
                  falls32++;
                  if (falls32 == 2) stop_run = hi_len;
               end
               hi_len = 0;
            end
         end
      end
   end
   initial begin
      forever begin
         @(posedge clk);
         #1;
         f32_empty = r32 ? 1'b1 : (pops32 >= 2);
      end
   end

   // ---------------- helpers ----------------
   task automatic start_phase();
      dec_q.delete(); exp_words.delete(); runs.delete();
      rd_cnt = 0; done_cnt = 0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok;
      ok = 0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         #1;
         if (q.size() == 0 && !tx_busy && !model_busy && !pop_req && !fifo_rd) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL %s_timeout: got busy expected idle within 20000 clks", nm);
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic cmp_words(input string nm);
      chk({nm, "_count"}, dec_q.size(), exp_words.size());
      for (int i = 0; i < dec_q.size() && i < exp_words.size(); i++)
         chk({nm, "_word"}, int'(dec_q[i]), int'(exp_words[i]));
   endtask

   function automatic int run_at(input int i);
      return (i < runs.size()) ? runs[i] : -1;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before 90000 clks");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 0;
      r32 = 0;

      // idle after reset
      start_phase();
      repeat (1000) @(posedge clk);
      #1;
      chk("idle_tx", int'(tx), 1);
      chk("idle_busy", int'(tx_busy), 0);
      chk("idle_rd_cnt", rd_cnt, 0);

      // single word 0xA5
      start_phase();
      push(8'hA5);
      wait_idle("a5");
      cmp_words("a5");
      chk("a5_line", int'(last_bits), int'(10'b1101001010));
      chk("a5_runs", int'(runs.size() >= 4), 1);
      chk("a5_start_len", int'(run_at(1) >= BITC - DVSR + 1 && run_at(1) <= BITC), 1);
      chk("a5_bit0_len", run_at(2), 64);
      chk("a5_bit1_len", run_at(3), 64);
      chk("a5_rd_cnt", rd_cnt, 1);
      chk("a5_done_cnt", done_cnt, 1);
      chk("a5_busy_end", int'(tx_busy), 0);

      // three queued words, back to back
      start_phase();
      push(8'h00); push(8'hFF); push(8'h3C);
      wait_idle("b2b");
      cmp_words("b2b");
      chk("b2b_rd_cnt", rd_cnt, 3);
      chk("b2b_done_cnt", done_cnt, 3);

      // reset in the middle of data bit 3 of 0x5A
      start_phase();
      push(8'h5A);
      begin
         bit hit;
         hit = 0;
         for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            if (model_busy && T >= 16 * 4 + 8) begin hit = 1; break; end
         end
         chk("abort_reached_bit3", int'(hit), 1);
      end
      push(8'h11);
      #1;
      reset = 1;
      #1;
      chk("abort_tx", int'(tx), 1);
      chk("abort_busy", int'(tx_busy), 0);
      chk("abort_rd", int'(fifo_rd), 0);
      chk("abort_done", int'(tx_done_tick), 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      void'(exp_words.pop_front());
      wait_idle("abort");
      cmp_words("abort");
      chk("abort_done_cnt", done_cnt, 1);
      chk("abort_rd_cnt", rd_cnt, 2);

      // 0xC3 while the data bus carries junk
      start_phase();
      push(8'hC3);
      wait_idle("junk");
      cmp_words("junk");
      chk("junk_line", int'(last_bits), int'(10'b1110000110));

      // randomized bursts and gaps
      start_phase();
      for (int it = 0; it < 8; it++) begin
         int nw;
         nw = $urandom_range(1, 3);
         for (int j = 0; j < nw; j++) push(8'($urandom));
         repeat ($urandom_range(0, 700)) @(posedge clk);
      end
      wait_idle("rand");
      cmp_words("rand");
      chk("rand_rd_cnt", rd_cnt, exp_words.size());
      chk("rand_done_cnt", done_cnt, exp_words.size());

      // two stop bits: high run = bit7 (1) + 128 stop clks, +/- tick phase
      begin
         bit got;
         got = 0;
         for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            if (stop_run > 0) begin got = 1; break; end
         end
         chk("sb32_measured", int'(got), 1);
         chk("sb32_stop_len", int'((stop_run - 64) >= 128 && (stop_run - 64) <= 128 + DVSR), 1);
         chk("sb32_pops", pops32, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
